// File: rtl/alu_pkg.sv
// Opcode encodings shared by the operand issue stage and the ALU select decode.
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 2'b00;
    localparam alu_op_t OP_SUB = 2'b01;
    localparam alu_op_t OP_AND = 2'b10;
    localparam alu_op_t OP_OR  = 2'b11;

    localparam int OP_W = $bits(alu_op_t);

endpackage

// File: rtl/alu_operand_issue_if.sv
// Host-side and ALU-side handshake bundle of the operand issue stage.
interface alu_operand_issue_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic             i_VALID;
    logic             o_READY;
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
    alu_op_t          i_OP;

    logic             o_VALID;
    logic             i_READY;
    logic [WIDTH-1:0] o_A;
    logic [WIDTH-1:0] o_B;
    alu_op_t          o_SEL;
    logic [ADDR_W:0]  o_LEVEL;

    modport slave (
        input  i_VALID, i_A, i_B, i_OP, i_READY,
        output o_READY, o_VALID, o_A, o_B, o_SEL, o_LEVEL
    );

    modport master (
        output i_VALID, i_A, i_B, i_OP, i_READY,
        input  o_READY, o_VALID, o_A, o_B, o_SEL, o_LEVEL
    );

endinterface

// File: rtl/alu_operand_issue_fifo.sv
// First-word-fall-through FIFO; head is read straight from storage, no write-to-read bypass.
module sync_fifo_fwft #(
    parameter int WIDTH_D = 10,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH_D-1:0]       wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH_D-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH_D-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // Acceptance looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign push  = wr_valid && !full;
    assign pop   = rd_ready && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= wr_data;
    end

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr];
    assign level    = count;

endmodule

// File: rtl/alu_operand_issue.sv
// Operand/opcode issue stage: buffers {OP, A, B} triples and presents them in order to the ALU.
module alu_operand_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_FLUSH,
    alu_operand_issue_if.slave bus
);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int WIDTH_D = 2*WIDTH + OP_W;

    logic [WIDTH_D-1:0] wr_word;
    logic [WIDTH_D-1:0] head;
    logic               head_valid;
    logic [ADDR_W:0]    level;

    assign wr_word = {bus.i_OP, bus.i_A, bus.i_B};

    sync_fifo_fwft #(
        .WIDTH_D (WIDTH_D),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk      (i_CLK),
        .rst      (i_RST),
        .flush    (i_FLUSH),
        .wr_valid (bus.i_VALID),
        .wr_ready (bus.o_READY),
        .wr_data  (wr_word),
        .rd_valid (head_valid),
        .rd_ready (bus.i_READY),
        .rd_data  (head),
        .level    (level)
    );

    // Storage is not reset, so stale words are masked off whenever the FIFO is empty.
    assign bus.o_VALID = head_valid;
    assign bus.o_SEL   = head_valid ? alu_op_t'(head[WIDTH_D-1 -: OP_W]) : OP_ADD;
    assign bus.o_A     = head_valid ? head[2*WIDTH-1 -: WIDTH] : '0;
    assign bus.o_B     = head_valid ? head[WIDTH-1:0] : '0;
    assign bus.o_LEVEL = level;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Scoreboard bench for alu_operand_issue: a queue model tracks accepted triples and expected pops.
module tb_alu_operand_issue;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    alu_operand_issue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    alu_operand_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_FLUSH (flush),
        .bus     (bus)
    );

    logic [9:0] exp_q [$];
    logic [9:0] exp_pop;
    logic [9:0] exp_head;
    logic [9:0] pre_word;
    logic       pre_valid;
    logic       pop_happened;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic set_in(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input alu_op_t op, input logic rdy);
        bus.i_VALID = v;
        bus.i_A     = a;
        bus.i_B     = b;
        bus.i_OP    = op;
        bus.i_READY = rdy;
    endtask

    // Advances one clock; the model decides push/pop from its own occupancy before the edge.
    task automatic cycle();
        logic do_push;
        logic do_pop;
        pre_valid    = bus.o_VALID;
        pre_word     = {bus.o_SEL, bus.o_A, bus.o_B};
        do_push      = bus.i_VALID && (exp_q.size() < DEPTH);
        do_pop       = bus.i_READY && (exp_q.size() > 0);
        pop_happened = 1'b0;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) begin
                exp_pop      = exp_q.pop_front();
                pop_happened = 1'b1;
            end
            if (do_push) exp_q.push_back({bus.i_OP, bus.i_A, bus.i_B});
        end
        @(posedge clk);
        #1;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : 10'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if ({bus.o_VALID, bus.o_READY, bus.o_LEVEL, bus.o_SEL, bus.o_A, bus.o_B} !== {1'b0, 1'b1, 3'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL reset: got valid=%b ready=%b level=%0d word=%h, expected valid=0 ready=1 level=0 word=000",
                     bus.o_VALID, bus.o_READY, bus.o_LEVEL, {bus.o_SEL, bus.o_A, bus.o_B});
        end
    endtask

    task automatic test_single_hold();
        set_in(1'b1, 4'd3, 4'd5, OP_ADD, 1'b0);
        cycle();
        set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0);
        n_checks++;
        if ({bus.o_VALID, bus.o_A, bus.o_B, bus.o_SEL, bus.o_LEVEL} !== {1'b1, 4'd3, 4'd5, OP_ADD, 3'd1}) begin
            n_fail++;
            $display("FAIL single_push: got valid=%b A=%0d B=%0d SEL=%b level=%0d, expected 1 3 5 00 1",
                     bus.o_VALID, bus.o_A, bus.o_B, bus.o_SEL, bus.o_LEVEL);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (bus.o_VALID !== 1'b1 || {bus.o_SEL, bus.o_A, bus.o_B} !== exp_head) begin
                n_fail++;
                $display("FAIL hold_%0d: got valid=%b word=%h, expected valid=1 word=%h",
                         i, bus.o_VALID, {bus.o_SEL, bus.o_A, bus.o_B}, exp_head);
            end
        end
        set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
        cycle();
        n_checks++;
        if (!pop_happened || pre_word !== exp_pop || bus.o_VALID !== 1'b0 || bus.o_LEVEL !== 3'd0) begin
            n_fail++;
            $display("FAIL single_pop: got word=%h valid_after=%b level=%0d, expected word=%h valid_after=0 level=0",
                     pre_word, bus.o_VALID, bus.o_LEVEL, exp_pop);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 4'(i), 4'(i + 8), alu_op_t'(i), 1'b0);
            cycle();
        end
        n_checks++;
        if (bus.o_LEVEL !== 3'd4 || bus.o_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: got level=%0d ready=%b, expected level=4 ready=0", bus.o_LEVEL, bus.o_READY);
        end
        set_in(1'b1, 4'd9, 4'd9, OP_OR, 1'b0);
        cycle();
        n_checks++;
        if (bus.o_LEVEL !== 3'd4 || {bus.o_SEL, bus.o_A, bus.o_B} !== exp_head) begin
            n_fail++;
            $display("FAIL push_full: got level=%0d word=%h, expected level=4 word=%h",
                     bus.o_LEVEL, {bus.o_SEL, bus.o_A, bus.o_B}, exp_head);
        end
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
            cycle();
            n_checks++;
            if (!pop_happened || pre_valid !== 1'b1 || pre_word !== exp_pop || pre_word[7:4] !== 4'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: got valid=%b word=%h, expected valid=1 word=%h A=%0d",
                         i, pre_valid, pre_word, exp_pop, i);
            end
        end
        n_checks++;
        if (bus.o_VALID !== 1'b0 || bus.o_LEVEL !== 3'd0) begin
            n_fail++;
            $display("FAIL drained: got valid=%b level=%0d, expected valid=0 level=0", bus.o_VALID, bus.o_LEVEL);
        end
    endtask

    task automatic test_full_pushpop();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 4'(i), 4'(15 - i), OP_SUB, 1'b0);
            cycle();
        end
        set_in(1'b1, 4'd9, 4'd9, OP_AND, 1'b1);
        cycle();
        n_checks++;
        if (pre_word !== exp_pop || pre_word[7:4] !== 4'd1 || bus.o_LEVEL !== 3'd3) begin
            n_fail++;
            $display("FAIL full_pushpop: got popped=%h level=%0d, expected popped=%h level=3",
                     pre_word, bus.o_LEVEL, exp_pop);
        end
        for (int i = 2; i <= 4; i++) begin
            set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
            cycle();
            n_checks++;
            if (pre_valid !== 1'b1 || pre_word !== exp_pop || pre_word[7:4] !== 4'(i)) begin
                n_fail++;
                $display("FAIL full_drain_%0d: got valid=%b word=%h, expected word=%h",
                         i, pre_valid, pre_word, exp_pop);
            end
        end
        n_checks++;
        if (bus.o_VALID !== 1'b0 || bus.o_LEVEL !== 3'd0) begin
            n_fail++;
            $display("FAIL full_not_stored: got valid=%b level=%0d, expected valid=0 level=0",
                     bus.o_VALID, bus.o_LEVEL);
        end
    endtask

    task automatic test_wrap_stream();
        set_in(1'b1, 4'd10, 4'd1, OP_AND, 1'b0);
        cycle();
        set_in(1'b1, 4'd11, 4'd2, OP_OR, 1'b0);
        cycle();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 4'(i), 4'(i ^ 5), alu_op_t'(i), 1'b1);
            cycle();
            n_checks++;
            if (pre_valid !== 1'b1 || !pop_happened || pre_word !== exp_pop || bus.o_LEVEL !== 3'd2) begin
                n_fail++;
                $display("FAIL stream_%0d: got valid=%b word=%h level=%0d, expected valid=1 word=%h level=2",
                         i, pre_valid, pre_word, bus.o_LEVEL, exp_pop);
            end
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
            cycle();
            n_checks++;
            if (pre_word !== exp_pop || pre_word[7:4] !== 4'(8 + i)) begin
                n_fail++;
                $display("FAIL stream_tail_%0d: got word=%h, expected word=%h", i, pre_word, exp_pop);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'(i + 4), 4'(i), OP_SUB, 1'b0);
            cycle();
        end
        n_checks++;
        if (bus.o_LEVEL !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_flush: got level=%0d, expected level=3", bus.o_LEVEL);
        end
        set_in(1'b1, 4'd7, 4'd7, OP_OR, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0);
        n_checks++;
        if ({bus.o_LEVEL, bus.o_VALID, bus.o_A, bus.o_READY} !== {3'd0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush: got level=%0d valid=%b A=%0d ready=%b, expected 0 0 0 1",
                     bus.o_LEVEL, bus.o_VALID, bus.o_A, bus.o_READY);
        end
        cycle();
        n_checks++;
        if (bus.o_VALID !== 1'b0 || bus.o_LEVEL !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_discard: got valid=%b level=%0d, expected valid=0 level=0",
                     bus.o_VALID, bus.o_LEVEL);
        end
    endtask

    task automatic test_mid_reset();
        set_in(1'b1, 4'd12, 4'd3, OP_AND, 1'b0);
        cycle();
        set_in(1'b1, 4'd13, 4'd4, OP_SUB, 1'b0);
        cycle();
        set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if ({bus.o_VALID, bus.o_READY, bus.o_LEVEL, bus.o_SEL, bus.o_A, bus.o_B} !== {1'b0, 1'b1, 3'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b ready=%b level=%0d word=%h, expected 0 1 0 000",
                     bus.o_VALID, bus.o_READY, bus.o_LEVEL, {bus.o_SEL, bus.o_A, bus.o_B});
        end
        set_in(1'b1, 4'd6, 4'd2, OP_OR, 1'b0);
        cycle();
        set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0);
        n_checks++;
        if ({bus.o_VALID, bus.o_SEL, bus.o_A, bus.o_B, bus.o_LEVEL} !== {1'b1, exp_head, 3'd1} ||
            exp_head !== {OP_OR, 4'd6, 4'd2}) begin
            n_fail++;
            $display("FAIL post_reset_push: got valid=%b word=%h level=%0d, expected valid=1 word=%h level=1",
                     bus.o_VALID, {bus.o_SEL, bus.o_A, bus.o_B}, bus.o_LEVEL, exp_head);
        end
        set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
        cycle();
        n_checks++;
        if (pre_word !== exp_pop || bus.o_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_pop: got word=%h valid_after=%b, expected word=%h valid_after=0",
                     pre_word, bus.o_VALID, exp_pop);
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0);
        #2;
        test_reset();
        test_single_hold();
        test_fill_drain();
        test_full_pushpop();
        test_wrap_stream();
        test_flush();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
